usb_rx_packet_ctrl: RTL and testbench

USB_RX_PACKET_CTRL -- requirements
Module: usb_rx_packet_ctrl

---
 rtl/usb_rx_packet_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_usb_rx_packet_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_ctrl.sv
// USB full/low-speed receive packet decoder: PID check, token field capture with CRC5,
// data payload streaming with CRC16 and a 2-byte hold-back, handshake length checks.
`timescale 1ns/1ps
module usb_rx_packet_ctrl #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic [3:0] pid,
  output logic       tok_valid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       dat_valid,
  output logic [7:0] dat_byte,
  output logic       pkt_done,
  output logic [2:0] pkt_status
);

  localparam int CW = $clog2(MAX_PAYLOAD + 3) + 1;
  localparam logic [CW-1:0] C_SAT    = {CW{1'b1}};
  localparam logic [CW-1:0] C_TWO    = CW'(2);
  localparam logic [CW-1:0] C_BABBLE = CW'(MAX_PAYLOAD + 2);

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_PID_ERR = 3'd1;
  localparam logic [2:0] ST_CRC_ERR = 3'd2;
  localparam logic [2:0] ST_LEN_ERR = 3'd3;
  localparam logic [2:0] ST_RX_ERR  = 3'd4;
  localparam logic [2:0] ST_BABBLE  = 3'd5;

  localparam logic [4:0]  CRC5_RES  = 5'b01100;
  localparam logic [15:0] CRC16_RES = 16'h800D;

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DISCARD, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic          r_act_d;
  logic          r_f_rx, r_f_pid, r_f_bab;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_crc5;
  logic [15:0]   r_crc16;
  logic [7:0]    r_tb1;
  logic [2:0]    r_tb2;
  logic [7:0]    r_d0, r_d1;

  logic [3:0] r_pid;
  logic       r_tok_valid;
  logic [6:0] r_tok_addr;
  logic [3:0] r_tok_endp;
  logic       r_dat_valid;
  logic [7:0] r_dat_byte;
  logic       r_pkt_done;
  logic [2:0] r_status;

  logic       w_rise, w_fall, w_pid_ok;
  logic       w_start, w_end, w_err, w_byte, w_emit, w_babble;
  logic       w_len_err, w_crc_err, w_no_pid, w_tok_ok;
  logic [2:0] w_status;

  // Both CRCs shift LSB of each byte first, matching wire order.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'h05 : 5'h00);
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction

  assign w_rise   = rx_active & ~r_act_d;
  assign w_fall   = ~rx_active & r_act_d;
  assign w_pid_ok = (rx_data[7:4] == ~rx_data[3:0]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_end    = 1'b0;
    w_err    = 1'b0;
    w_byte   = 1'b0;
    w_emit   = 1'b0;
    w_babble = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_next  = S_PID;
          w_start = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (w_rise) begin
          w_next  = S_PID;
          w_start = 1'b1;
        end
      end
      default: begin
        if (w_fall) begin
          w_next = S_DONE;
          w_end  = 1'b1;
        end else if (rx_active && rx_error) begin
          w_next = S_DISCARD;
          w_err  = 1'b1;
        end else if (rx_active && rx_valid && r_state != S_DISCARD) begin
          w_byte = 1'b1;
          case (r_state)
            S_PID: begin
              if (!w_pid_ok) w_next = S_DISCARD;
              else begin
                case (rx_data[1:0])
                  2'b01:   w_next = S_TOKEN;
                  2'b11:   w_next = S_DATA;
                  2'b10:   w_next = S_HSK;
                  default: w_next = S_DISCARD;
                endcase
              end
            end
            S_DATA: begin
              // r_cnt counts bytes after PID before this one; byte N leaves when N+2 arrives.
              if (r_cnt == C_BABBLE) begin
                w_babble = 1'b1;
                w_next   = S_DISCARD;
              end else if (r_cnt >= C_TWO) begin
                w_emit = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_len_err = 1'b0;
    w_crc_err = 1'b0;
    w_no_pid  = (r_state == S_PID);
    case (r_state)
      S_TOKEN: begin
        w_len_err = (r_cnt != C_TWO);
        w_crc_err = (r_crc5 != CRC5_RES);
      end
      S_DATA: begin
        w_len_err = (r_cnt < C_TWO);
        w_crc_err = (r_crc16 != CRC16_RES);
      end
      S_HSK:   w_len_err = (r_cnt != '0);
      default: ;
    endcase
    if      (r_f_rx)              w_status = ST_RX_ERR;
    else if (r_f_pid || w_no_pid) w_status = ST_PID_ERR;
    else if (r_f_bab)             w_status = ST_BABBLE;
    else if (w_len_err)           w_status = ST_LEN_ERR;
    else if (w_crc_err)           w_status = ST_CRC_ERR;
    else                          w_status = ST_OK;
    w_tok_ok = (r_state == S_TOKEN) && (w_status == ST_OK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Held high so an rx_active still asserted across reset release is not a new packet.
      r_act_d     <= 1'b1;
      r_f_rx      <= 1'b0;
      r_f_pid     <= 1'b0;
      r_f_bab     <= 1'b0;
      r_cnt       <= '0;
      r_crc5      <= 5'h1F;
      r_crc16     <= 16'hFFFF;
      r_tb1       <= '0;
      r_tb2       <= '0;
      r_d0        <= '0;
      r_d1        <= '0;
      r_pid       <= '0;
      r_tok_valid <= 1'b0;
      r_tok_addr  <= '0;
      r_tok_endp  <= '0;
      r_dat_valid <= 1'b0;
      r_dat_byte  <= '0;
      r_pkt_done  <= 1'b0;
      r_status    <= ST_OK;
    end else begin
      r_act_d     <= rx_active;
      r_pkt_done  <= w_end;
      r_tok_valid <= w_end & w_tok_ok;
      r_dat_valid <= w_emit;
      if (w_end) r_status <= w_status;
      if (w_end && w_tok_ok) begin
        r_tok_addr <= r_tb1[6:0];
        r_tok_endp <= {r_tb2, r_tb1[7]};
      end
      if (w_emit) r_dat_byte <= r_d1;
      if (w_start) begin
        r_f_rx  <= 1'b0;
        r_f_pid <= 1'b0;
        r_f_bab <= 1'b0;
        r_cnt   <= '0;
        r_crc5  <= 5'h1F;
        r_crc16 <= 16'hFFFF;
      end else begin
        if (w_err)    r_f_rx  <= 1'b1;
        if (w_babble) r_f_bab <= 1'b1;
        if (w_byte) begin
          case (r_state)
            S_PID: begin
              r_pid <= rx_data[3:0];
              if (!w_pid_ok) r_f_pid <= 1'b1;
            end
            S_TOKEN: begin
              r_cnt  <= (r_cnt == C_SAT) ? r_cnt : r_cnt + 1'b1;
              r_crc5 <= crc5_byte(r_crc5, rx_data);
              if (r_cnt == '0)        r_tb1 <= rx_data;
              if (r_cnt == CW'(1))    r_tb2 <= rx_data[2:0];
            end
            S_DATA: begin
              r_cnt   <= r_cnt + 1'b1;
              r_crc16 <= crc16_byte(r_crc16, rx_data);
              r_d0    <= rx_data;
              r_d1    <= r_d0;
            end
            S_HSK:   r_cnt <= (r_cnt == C_SAT) ? r_cnt : r_cnt + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign pid        = r_pid;
  assign tok_valid  = r_tok_valid;
  assign tok_addr   = r_tok_addr;
  assign tok_endp   = r_tok_endp;
  assign dat_valid  = r_dat_valid;
  assign dat_byte   = r_dat_byte;
  assign pkt_done   = r_pkt_done;
  assign pkt_status = r_status;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl: a packet table plus hand-built sequences
// for babble, rx_error, reset mid-packet and back-to-back packets.
`timescale 1ns/1ps
module tb_usb_rx_packet_ctrl;
  localparam int MAXP = 64;
  localparam int NV   = 12;

  logic       clk = 1'b0, reset = 1'b1;
  logic       rx_active = 1'b0, rx_valid = 1'b0, rx_error = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] pid;
  logic       tok_valid, dat_valid, pkt_done;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic [7:0] dat_byte;
  logic [2:0] pkt_status;

  always #5 clk = ~clk;

  usb_rx_packet_ctrl #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .reset(reset), .rx_active(rx_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_error(rx_error), .pid(pid), .tok_valid(tok_valid),
    .tok_addr(tok_addr), .tok_endp(tok_endp), .dat_valid(dat_valid),
    .dat_byte(dat_byte), .pkt_done(pkt_done), .pkt_status(pkt_status)
  );

  typedef struct packed {
    logic [0:15][7:0] b;
    logic [4:0]       n;
    logic [3:0]       pid;
    logic [2:0]       st;
    logic             tok;
    logic [6:0]       addr;
    logic [3:0]       endp;
    logic [3:0]       ns;
    logic [0:7][7:0]  s;
  } vec_t;

  vec_t vt [NV];

  int n_chk = 0, n_fail = 0;
  int done_total = 0, tok_total = 0, tok_lone = 0;
  logic [7:0] sq [$];
  logic [2:0] st_q [$];
  logic [6:0] exp_addr = '0;
  logic [3:0] exp_endp = '0;
  int d0, t0, s0;

  always @(negedge clk) begin
    if (dat_valid) sq.push_back(dat_byte);
    if (pkt_done) begin
      done_total <= done_total + 1;
      st_q.push_back(pkt_status);
    end
    if (tok_valid) begin
      tok_total <= tok_total + 1;
      if (!pkt_done) tok_lone <= tok_lone + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] n, input logic [3:0] p, input logic [2:0] st,
                               input logic tok, input logic [6:0] a, input logic [3:0] e,
                               input logic [3:0] ns);
    vec_t r;
    r = '0;
    r.n = n; r.pid = p; r.st = st; r.tok = tok; r.addr = a; r.endp = e; r.ns = ns;
    return r;
  endfunction

  task automatic start_pkt();
    @(posedge clk); #1 rx_active = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  // Leaves the caller at the negedge where pkt_done must be high.
  task automatic stop_pkt(input string nm);
    @(posedge clk); #1 rx_active = 1'b0;
    @(negedge clk); check({nm, " done_early"}, pkt_done, 0);
    @(negedge clk); check({nm, " done_lat"}, pkt_done, 1);
  endtask

  task automatic run_vec(input int v);
    int dd, tt, ss;
    string nm;
    nm = $sformatf("v%0d", v);
    dd = done_total; tt = tok_total; ss = sq.size();
    start_pkt();
    for (int i = 0; i < int'(vt[v].n); i++) send_byte(vt[v].b[i]);
    stop_pkt(nm);
    check({nm, " status"}, pkt_status, vt[v].st);
    check({nm, " tok_valid"}, tok_valid, vt[v].tok);
    check({nm, " pid"}, pid, vt[v].pid);
    if (vt[v].tok) begin
      exp_addr = vt[v].addr;
      exp_endp = vt[v].endp;
    end
    @(negedge clk);
    check({nm, " done_1clk"}, pkt_done, 0);
    check({nm, " tok_addr"}, tok_addr, exp_addr);
    check({nm, " tok_endp"}, tok_endp, exp_endp);
    @(negedge clk);
    check({nm, " done_cnt"}, done_total - dd, 1);
    check({nm, " tok_cnt"}, tok_total - tt, vt[v].tok);
    check({nm, " strobes"}, sq.size() - ss, vt[v].ns);
    if (sq.size() - ss == int'(vt[v].ns))
      for (int j = 0; j < int'(vt[v].ns); j++)
        check($sformatf("%s byte%0d", nm, j), sq[ss + j], vt[v].s[j]);
  endtask

  task automatic send_data_burst(input int npay, input logic [7:0] c0, input logic [7:0] c1);
    logic [7:0] bv;
    start_pkt();
    send_byte(8'h4B);
    for (int i = 0; i < npay; i++) begin
      bv = 8'(i + 1);
      send_byte(bv);
    end
    send_byte(c0);
    send_byte(c1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mkv(3,  4'hD, 0, 1, 7'h00, 4'h0, 0); vt[0].b[0:2]  = {8'h2D, 8'h00, 8'h10};
    vt[1]  = mkv(3,  4'h9, 0, 1, 7'h15, 4'hE, 0); vt[1].b[0:2]  = {8'h69, 8'h15, 8'hEF};
    vt[2]  = mkv(3,  4'h9, 2, 0, 7'h00, 4'h0, 0); vt[2].b[0:2]  = {8'h69, 8'h15, 8'hEE};
    vt[3]  = mkv(2,  4'h1, 3, 0, 7'h00, 4'h0, 0); vt[3].b[0:1]  = {8'hE1, 8'h15};
    vt[4]  = mkv(11, 4'h3, 0, 0, 7'h00, 4'h0, 8);
    vt[4].b[0:10] = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    vt[4].s = {8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    vt[5] = vt[4]; vt[5].st = 3'd2; vt[5].b[10] = 8'h95;
    vt[6]  = mkv(1,  4'h2, 0, 0, 7'h00, 4'h0, 0); vt[6].b[0]    = 8'hD2;
    vt[7]  = mkv(2,  4'h2, 3, 0, 7'h00, 4'h0, 0); vt[7].b[0:1]  = {8'hD2, 8'h00};
    vt[8]  = mkv(3,  4'hC, 1, 0, 7'h00, 4'h0, 0); vt[8].b[0:2]  = {8'h2C, 8'h00, 8'h10};
    vt[9]  = mkv(2,  4'hB, 3, 0, 7'h00, 4'h0, 0); vt[9].b[0:1]  = {8'h4B, 8'h00};
    vt[10] = mkv(3,  4'hB, 0, 0, 7'h00, 4'h0, 0); vt[10].b[0:2] = {8'h4B, 8'h00, 8'h00};
    vt[11] = mkv(3,  4'hC, 0, 0, 7'h00, 4'h0, 0); vt[11].b[0:2] = {8'h3C, 8'h01, 8'h02};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {pid, tok_valid, tok_addr, tok_endp, dat_valid, dat_byte, pkt_done, pkt_status}, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle no done", done_total, 0);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Payload one past the limit: MAXP strobes, then BABBLE.
    d0 = done_total; s0 = sq.size();
    send_data_burst(MAXP + 1, 8'h00, 8'h00);
    stop_pkt("babble");
    check("babble status", pkt_status, 5);
    repeat (2) @(negedge clk);
    check("babble strobes", sq.size() - s0, MAXP);
    if (sq.size() - s0 == MAXP) begin
      check("babble first", sq[s0], 8'h01);
      check("babble last", sq[s0 + MAXP - 1], 8'(MAXP));
    end

    // Exactly MAXP payload bytes with a wrong CRC: no babble, CRC_ERR.
    s0 = sq.size();
    send_data_burst(MAXP, 8'h00, 8'h00);
    stop_pkt("maxpay");
    check("maxpay status", pkt_status, 2);
    repeat (2) @(negedge clk);
    check("maxpay strobes", sq.size() - s0, MAXP);

    // rx_error during the last token byte; that byte is dropped.
    t0 = tok_total;
    start_pkt();
    send_byte(8'h69);
    send_byte(8'h15);
    @(posedge clk); #1 rx_error = 1'b1; rx_valid = 1'b1; rx_data = 8'hEF;
    @(posedge clk); #1 rx_error = 1'b0; rx_valid = 1'b0;
    stop_pkt("rxerr");
    check("rxerr status", pkt_status, 4);
    check("rxerr tok_valid", tok_valid, 0);
    repeat (2) @(negedge clk);
    check("rxerr tok_cnt", tok_total - t0, 0);
    check("rxerr addr held", tok_addr, exp_addr);

    // Reset after 3 DATA bytes, rx_active held across release.
    d0 = done_total; s0 = sq.size();
    start_pkt();
    send_byte(8'hC3);
    send_byte(8'h80);
    send_byte(8'h06);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send_byte(8'hD2);
    @(posedge clk); #1 rx_active = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid no done", done_total - d0, 0);
    check("rst_mid strobes", sq.size() - s0, 0);
    check("rst_mid pid", pid, 0);
    check("rst_mid tok_addr", tok_addr, 0);
    exp_addr = '0; exp_endp = '0;
    run_vec(1);

    // Back-to-back: rx_active low for one clk between packets.
    d0 = done_total; t0 = tok_total;
    start_pkt();
    send_byte(8'hD2);
    send_byte(8'h00);
    @(posedge clk); #1 rx_active = 1'b0;
    @(posedge clk); #1 rx_active = 1'b1;
    send_byte(8'h2D);
    send_byte(8'h00);
    send_byte(8'h10);
    stop_pkt("b2b");
    check("b2b tok_valid", tok_valid, 1);
    repeat (2) @(negedge clk);
    check("b2b done_cnt", done_total - d0, 2);
    check("b2b tok_cnt", tok_total - t0, 1);
    if (done_total - d0 == 2) begin
      check("b2b st first", st_q[d0], 3);
      check("b2b st second", st_q[d0 + 1], 0);
    end
    check("tok without done", tok_lone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
